// File: rtl/udp_pkt_chk.sv
// udp_pkt_chk: MAC RX frame checker with good/bad pulses, sequence tracking and counters.
// Define UDP_PKT_CHK_IP_CSUM_EN to also verify the IPv4 header checksum.
module udp_pkt_chk #(
  parameter logic [47:0] TARGET_MAC = 48'h00_C0_A8_7F_8B_A4,
  parameter logic [15:0] ETHERTYPE  = 16'h0800,
  parameter logic [31:0] DEST_IP    = 32'hC0A80502,
  parameter logic [15:0] DEST_PORT  = 16'hCAFE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mac_rx_valid,
  input  logic [31:0] mac_rx_data,
  input  logic [3:0]  mac_rx_eof,
  input  logic        mac_rx_err,
  output logic        pkt_ok,
  output logic        pkt_bad,
  output logic        seq_err,
  output logic [31:0] payload,
  output logic [15:0] ok_count,
  output logic [15:0] bad_count
);
  typedef enum logic {RECV, DROP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        bad_q, bad_d, have_prev_q, have_prev_d;
  logic        pkt_ok_q, pkt_ok_d, pkt_bad_q, pkt_bad_d, seq_err_q, seq_err_d;
  logic [31:0] payload_q, payload_d;
  logic [15:0] ok_count_q, ok_count_d, bad_count_q, bad_count_d;
  logic        eof, conclude, mismatch, csum_bad, bad_now, good;

  always_comb begin
    mismatch = (idx_q == 4'd0) ? mac_rx_data != TARGET_MAC[47:16] :
               (idx_q == 4'd1) ? mac_rx_data != {TARGET_MAC[15:0], ETHERTYPE} :
               (idx_q == 4'd2) ? mac_rx_data[31:24] != 8'h45 || mac_rx_data[15:0] != 16'h0020 :
               (idx_q == 4'd4) ? mac_rx_data[23:16] != 8'h11 :
               (idx_q == 4'd6) ? mac_rx_data != DEST_IP :
               (idx_q == 4'd7) ? mac_rx_data[15:0] != DEST_PORT :
               (idx_q == 4'd8) ? mac_rx_data[31:16] != 16'h000C : 1'b0;
    eof      = |mac_rx_eof;
    conclude = mac_rx_valid & eof;
    bad_now  = bad_q | mac_rx_err | mismatch | csum_bad;
    good     = state_q == RECV && idx_q == 4'd9 && !bad_now;
  end

`ifdef UDP_PKT_CHK_IP_CSUM_EN
  logic [17:0] csum_t;
  logic [16:0] csum_q, csum_d, csum_f;
  logic [15:0] csum_fin;
  // End-around carry is folded after every word so the sum never overflows 17 bits.
  always_comb begin
    csum_t   = (idx_q == 4'd2 ? 18'd0 : {1'b0, csum_q}) + {2'b0, mac_rx_data[31:16]} + {2'b0, mac_rx_data[15:0]};
    csum_f   = {1'b0, csum_t[15:0]} + {15'd0, csum_t[17:16]};
    csum_fin = csum_f[15:0] + {15'd0, csum_f[16]};
    csum_d   = (mac_rx_valid && state_q == RECV && idx_q >= 4'd2 && idx_q <= 4'd6) ? csum_f : csum_q;
    csum_bad = idx_q == 4'd6 && csum_fin != 16'hFFFF;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) csum_q <= '0;
    else csum_q <= csum_d;
`else
  assign csum_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RECV;
      idx_q       <= '0;
      bad_q       <= 1'b0;
      have_prev_q <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_bad_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      payload_q   <= '0;
      ok_count_q  <= '0;
      bad_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      bad_q       <= bad_d;
      have_prev_q <= have_prev_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_bad_q   <= pkt_bad_d;
      seq_err_q   <= seq_err_d;
      payload_q   <= payload_d;
      ok_count_q  <= ok_count_d;
      bad_count_q <= bad_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    if (conclude) begin
      state_d = RECV;
      idx_d   = '0;
      bad_d   = 1'b0;
    end else if (mac_rx_valid && state_q == RECV) begin
      state_d = idx_q == 4'd9 ? DROP : RECV;
      idx_d   = idx_q == 4'd9 ? idx_q : idx_q + 4'd1;
      bad_d   = bad_now | (idx_q == 4'd9);
    end
  end

  // Last good payload doubles as the sequence reference.
  always_comb begin
    pkt_ok_d    = conclude & good;
    pkt_bad_d   = conclude & ~good;
    seq_err_d   = pkt_ok_d & have_prev_q & (mac_rx_data != payload_q + 32'd1);
    payload_d   = pkt_ok_d ? mac_rx_data : payload_q;
    have_prev_d = have_prev_q | pkt_ok_d;
    ok_count_d  = ok_count_q + {15'd0, pkt_ok_d};
    bad_count_d = bad_count_q + {15'd0, pkt_bad_d};
  end

  assign pkt_ok    = pkt_ok_q;
  assign pkt_bad   = pkt_bad_q;
  assign seq_err   = seq_err_q;
  assign payload   = payload_q;
  assign ok_count  = ok_count_q;
  assign bad_count = bad_count_q;
endmodule

// File: tb/tb_udp_pkt_chk.sv
// tb_udp_pkt_chk: directed frames with hand-computed results, checked by a scoreboard monitor.
module tb_udp_pkt_chk;
  logic        clk = 0, reset_n = 0, mac_rx_valid = 0, mac_rx_err = 0;
  logic [31:0] mac_rx_data = '0;
  logic [3:0]  mac_rx_eof = '0;
  logic        pkt_ok, pkt_bad, seq_err;
  logic [31:0] payload;
  logic [15:0] ok_count, bad_count;
  int cyc = 0, checks = 0, errors = 0;

  typedef struct {
    logic ok; logic bad; logic seq; logic [31:0] pay; logic [15:0] okc; logic [15:0] badc; int cyc;
  } exp_t;
  exp_t sbq[$];

  udp_pkt_chk dut (
    .clk(clk), .reset_n(reset_n), .mac_rx_valid(mac_rx_valid), .mac_rx_data(mac_rx_data),
    .mac_rx_eof(mac_rx_eof), .mac_rx_err(mac_rx_err), .pkt_ok(pkt_ok), .pkt_bad(pkt_bad),
    .seq_err(seq_err), .payload(payload), .ok_count(ok_count), .bad_count(bad_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Header checksum 2A7A is correct for this header (src IP C0A80501, id C4FF).
  function automatic logic [31:0] word(input int i, input logic [31:0] pl, input logic [15:0] cs, input logic [15:0] port);
    case (i)
      0: word = 32'h00C0A87F;
      1: word = 32'h8BA40800;
      2: word = 32'h45000020;
      3: word = 32'hC4FF0000;
      4: word = {16'h4011, cs};
      5: word = 32'hC0A80501;
      6: word = 32'hC0A80502;
      7: word = {16'h1234, port};
      8: word = 32'h000C0000;
      9: word = pl;
      default: word = 32'hDEADBEEF;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n && (pkt_ok || pkt_bad || seq_err)) begin
      exp_t e;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got ok=%0b bad=%0b seq=%0b at cycle %0d, expected no pulse", pkt_ok, pkt_bad, seq_err, cyc);
      end else begin
        e = sbq.pop_front();
        if ({pkt_ok, pkt_bad, seq_err, payload, ok_count, bad_count} !== {e.ok, e.bad, e.seq, e.pay, e.okc, e.badc} || cyc != e.cyc) begin
          errors++;
          $display("FAIL pkt_result: got ok=%0b bad=%0b seq=%0b payload=%h ok_count=%0d bad_count=%0d cyc=%0d, expected ok=%0b bad=%0b seq=%0b payload=%h ok_count=%0d bad_count=%0d cyc=%0d",
                   pkt_ok, pkt_bad, seq_err, payload, ok_count, bad_count, cyc, e.ok, e.bad, e.seq, e.pay, e.okc, e.badc, e.cyc);
        end
      end
    end
  end

  task automatic send_frame(input logic [31:0] pl, input logic [15:0] cs, input logic [15:0] port, input int last,
                            input logic err, input logic eok, input logic eseq, input logic [31:0] epay,
                            input logic [15:0] eokc, input logic [15:0] ebadc);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      mac_rx_valid = 1;
      mac_rx_data  = word(i, pl, cs, port);
      mac_rx_err   = err && i == 3;
      mac_rx_eof   = (i == last) ? 4'(1 << (last % 4)) : 4'd0;
      if (i == last) begin
        exp_t e;
        e.ok = eok; e.bad = !eok; e.seq = eseq; e.pay = epay; e.okc = eokc; e.badc = ebadc; e.cyc = cyc + 1;
        sbq.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mac_rx_valid = 0; mac_rx_eof = '0; mac_rx_err = 0;
    end
  endtask

  task automatic reset_check(input string name);
    mac_rx_valid = 0; mac_rx_eof = '0; mac_rx_err = 0;
    #2 reset_n = 0;
    #1 checks++;
    if ({pkt_ok, pkt_bad, seq_err, payload, ok_count, bad_count} !== '0) begin
      errors++;
      $display("FAIL %s: got ok=%0b bad=%0b seq=%0b payload=%h ok_count=%0d bad_count=%0d, expected all zero",
               name, pkt_ok, pkt_bad, seq_err, payload, ok_count, bad_count);
    end
    @(negedge clk);
    reset_n = 1;
  endtask

  initial begin
    int k;
    @(negedge clk);
    reset_check("reset_state");
    send_frame(32'h5, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'h5, 16'd1, 16'd0);
    idle(2);
    reset_check("reset_after_first");
    send_frame(32'h7, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'h7, 16'd1, 16'd0);
    send_frame(32'h8, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'h8, 16'd2, 16'd0);
    send_frame(32'hA, 16'h2A7A, 16'hCAFE, 9, 0, 1, 1, 32'hA, 16'd3, 16'd0);
    idle(1);
    send_frame(32'd99, 16'h2A7A, 16'hBEEF, 9, 0, 0, 0, 32'hA, 16'd3, 16'd1);
    send_frame(32'd55, 16'h2A7A, 16'hCAFE, 5, 0, 0, 0, 32'hA, 16'd3, 16'd2);
    send_frame(32'd66, 16'h2A7A, 16'hCAFE, 11, 0, 0, 0, 32'hA, 16'd3, 16'd3);
    send_frame(32'd11, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'd11, 16'd4, 16'd3);
    send_frame(32'd77, 16'h2A7A, 16'hCAFE, 9, 1, 0, 0, 32'd11, 16'd4, 16'd4);
    send_frame(32'hFFFFFFFF, 16'h2A7A, 16'hCAFE, 9, 0, 1, 1, 32'hFFFFFFFF, 16'd5, 16'd4);
    send_frame(32'h0, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'h0, 16'd6, 16'd4);
    idle(2);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      mac_rx_valid = 1; mac_rx_eof = '0; mac_rx_data = word(i, 32'h0, 16'h2A7A, 16'hCAFE);
    end
    @(negedge clk);
    reset_check("reset_mid_frame");
    send_frame(32'h5, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'h5, 16'd1, 16'd0);
    idle(1);
`ifdef UDP_PKT_CHK_IP_CSUM_EN
    send_frame(32'h6, 16'h2A7B, 16'hCAFE, 9, 0, 0, 0, 32'h5, 16'd1, 16'd1);
    send_frame(32'h7, 16'h2A7A, 16'hCAFE, 9, 0, 1, 1, 32'h7, 16'd2, 16'd1);
`else
    send_frame(32'h6, 16'h2A7B, 16'hCAFE, 9, 0, 1, 0, 32'h6, 16'd2, 16'd0);
    send_frame(32'h7, 16'h2A7A, 16'hCAFE, 9, 0, 1, 0, 32'h7, 16'd3, 16'd0);
`endif
    idle(1);
    k = 0;
    while (sbq.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_pulse: got %0d results outstanding, expected 0", sbq.size());
    end
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
